// File: rtl/fifo_pkg.sv
// fifo_pkg: shared parameter defaults and packet field offsets for the packet fifo
package fifo_pkg;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_WIDTH     = 11;
  localparam int DEF_UWIDTH    = 8;
  localparam int DEF_PTR_SZ    = 2;
  localparam int DEF_PTR_IN_SZ = 4;
  localparam int OFF_SRC       = 0;
  localparam int OFF_DST       = 1;
  localparam int OFF_SIZE      = 2;
  localparam int OFF_DATA      = 3;
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: slot x byte storage with one synchronous byte write port and one combinational byte read port
module fifo_mem import fifo_pkg::*; #(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int UWIDTH    = DEF_UWIDTH,
  parameter int PTR_SZ    = DEF_PTR_SZ,
  parameter int PTR_IN_SZ = DEF_PTR_IN_SZ
) (
  input  logic                 clk1,
  input  logic                 rst,
  input  logic                 we,
  input  logic [PTR_SZ-1:0]    wslot,
  input  logic [PTR_IN_SZ-1:0] waddr,
  input  logic [UWIDTH-1:0]    wdata,
  input  logic [PTR_SZ-1:0]    rslot,
  input  logic [PTR_IN_SZ-1:0] raddr,
  output logic [UWIDTH-1:0]    rdata
);
  logic [UWIDTH-1:0] mem [DEPTH][WIDTH];
  // store a byte into the staged slot; offsets past the packet are dropped, reset wipes every slot
  always_ff @(posedge clk1 or negedge rst)
    if (!rst) begin
      for (int s = 0; s < DEPTH; s++)
        for (int b = 0; b < WIDTH; b++)
          mem[s][b] <= '0;
    end else if (we && 32'(waddr) < WIDTH) begin
      mem[wslot][waddr] <= wdata;
    end
  // offsets past the packet read as zero
  always_comb rdata = (32'(raddr) < WIDTH) ? mem[rslot][raddr] : '0;
endmodule

// File: rtl/fifo.sv
// fifo: packet fifo of DEPTH slots, each slot filled byte-wise and committed as a whole
module fifo import fifo_pkg::*; #(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int UWIDTH    = DEF_UWIDTH,
  parameter int PTR_SZ    = DEF_PTR_SZ,
  parameter int PTR_IN_SZ = DEF_PTR_IN_SZ
) (
  input  logic                 clk1,
  input  logic                 rst,
  input  logic                 winc,
  input  logic                 rinc,
  input  logic [PTR_IN_SZ-1:0] waddr_in,
  input  logic [PTR_IN_SZ-1:0] raddr_in,
  input  logic [UWIDTH-1:0]    wdata,
  output logic [UWIDTH-1:0]    rdata,
  output logic                 wfull,
  output logic                 rempty
);
  logic [PTR_SZ:0] wptr, rptr;
  // pointers carry one extra wrap bit so full and empty are distinguishable
  always_ff @(posedge clk1 or negedge rst)
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= (winc && !wfull) ? wptr + 1'b1 : wptr;
      rptr <= (rinc && !rempty) ? rptr + 1'b1 : rptr;
    end
  // flags come straight from the registered pointers
  always_comb begin
    rempty = wptr == rptr;
    wfull  = (wptr[PTR_SZ-1:0] == rptr[PTR_SZ-1:0]) && (wptr[PTR_SZ] != rptr[PTR_SZ]);
  end
  fifo_mem #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .UWIDTH(UWIDTH), .PTR_SZ(PTR_SZ), .PTR_IN_SZ(PTR_IN_SZ)
  ) u_mem (
    .clk1 (clk1),
    .rst  (rst),
    .we   (!wfull),
    .wslot(wptr[PTR_SZ-1:0]),
    .waddr(waddr_in),
    .wdata(wdata),
    .rslot(rptr[PTR_SZ-1:0]),
    .raddr(raddr_in),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_fifo.sv
// tb_fifo: scenario tasks against a slot-level model and a queue of committed packets
module tb_fifo;
  import fifo_pkg::*;
  typedef logic [DEF_WIDTH-1:0][DEF_UWIDTH-1:0] pkt_t;
  logic clk1 = 0, rst = 0, winc = 0, rinc = 0;
  logic [3:0] waddr_in = 4'hf, raddr_in = 0;
  logic [7:0] wdata = 0;
  logic [7:0] rdata;
  logic wfull, rempty;
  int n_cmp = 0, n_err = 0;
  pkt_t mm [DEF_DEPTH];
  logic [2:0] mw = 0, mr = 0;
  pkt_t sb [$];
  logic [7:0] pk [$];
  logic [7:0] heads [$];

  fifo #(.DEPTH(4), .WIDTH(11), .UWIDTH(8), .PTR_SZ(2), .PTR_IN_SZ(4)) dut (
    .clk1(clk1), .rst(rst), .winc(winc), .rinc(rinc), .waddr_in(waddr_in),
    .raddr_in(raddr_in), .wdata(wdata), .rdata(rdata), .wfull(wfull), .rempty(rempty)
  );

  always #5 clk1 = ~clk1;

  task automatic model_clear();
    for (int s = 0; s < DEF_DEPTH; s++) mm[s] = '0;
    mw = 0;
    mr = 0;
    sb.delete();
  endtask

  task automatic drive(input logic w, input logic r, input logic [3:0] a, input logic [7:0] d);
    logic full, empty;
    full  = (mw[1:0] == mr[1:0]) && (mw[2] != mr[2]);
    empty = mw == mr;
    winc = w; rinc = r; waddr_in = a; wdata = d;
    if (!full && int'(a) < DEF_WIDTH) mm[mw[1:0]][a] = d;
    if (w && !full) begin sb.push_back(mm[mw[1:0]]); mw++; end
    if (r && !empty) begin void'(sb.pop_front()); mr++; end
    @(posedge clk1); #1;
    winc = 0; rinc = 0; waddr_in = 4'hf;
  endtask

  task automatic write_pkt(input logic r);
    for (int i = 0; i < pk.size(); i++)
      drive(i == pk.size() - 1, r && (i == pk.size() - 1), 4'(i), pk[i]);
  endtask

  task automatic test_reset();
    #2;
    n_cmp += 3;
    if (rempty !== 1'b1) begin n_err++; $display("FAIL reset_rempty: got %b want 1", rempty); end
    if (wfull !== 1'b0) begin n_err++; $display("FAIL reset_wfull: got %b want 0", wfull); end
    if (rdata !== 8'd0) begin n_err++; $display("FAIL reset_rdata: got %0d want 0", rdata); end
    @(posedge clk1); #1;
    rst = 1;
  endtask

  task automatic test_single();
    pk = '{10, 160, 3, 0, 1, 2, 15};
    write_pkt(0);
    n_cmp += 2;
    if (rempty !== 1'b0) begin n_err++; $display("FAIL single_rempty: got %b want 0", rempty); end
    if (wfull !== 1'b0) begin n_err++; $display("FAIL single_wfull: got %b want 0", wfull); end
    for (int i = 0; i < 7; i++) begin
      raddr_in = 4'(i); #1;
      n_cmp++;
      if (rdata !== pk[i]) begin n_err++; $display("FAIL single_byte%0d: got %0d want %0d", i, rdata, pk[i]); end
    end
    raddr_in = 4'd12; #1;
    n_cmp++;
    if (rdata !== 8'd0) begin n_err++; $display("FAIL oob_read: got %0d want 0", rdata); end
  endtask

  task automatic test_fill();
    pk = '{100, 10, 4, 0, 1, 2, 3, 55};
    write_pkt(0);
    pk = '{255, 63, 5, 0, 1, 2, 3, 4, 55};
    write_pkt(0);
    pk = '{63, 31, 6, 0, 1, 2, 3, 4, 5, 127};
    write_pkt(0);
    n_cmp++;
    if (wfull !== 1'b1) begin n_err++; $display("FAIL fill_wfull: got %b want 1", wfull); end
    drive(1, 0, 4'(OFF_SRC), 8'd99);
    raddr_in = 4'(OFF_SRC); #1;
    n_cmp += 3;
    if (wfull !== 1'b1) begin n_err++; $display("FAIL fifth_wfull: got %b want 1", wfull); end
    if (rempty !== 1'b0) begin n_err++; $display("FAIL fifth_rempty: got %b want 0", rempty); end
    if (rdata !== 8'd10) begin n_err++; $display("FAIL fifth_head: got %0d want 10", rdata); end
  endtask

  task automatic test_drain();
    heads = '{10, 100, 255, 63};
    for (int k = 0; k < 4; k++) begin
      for (int o = 0; o < DEF_WIDTH; o++) begin
        raddr_in = 4'(o); #1;
        n_cmp++;
        if (rdata !== sb[0][o]) begin n_err++; $display("FAIL drain%0d_byte%0d: got %0d want %0d", k, o, rdata, sb[0][o]); end
      end
      raddr_in = 4'(OFF_SRC); #1;
      n_cmp++;
      if (rdata !== heads[k]) begin n_err++; $display("FAIL drain%0d_src: got %0d want %0d", k, rdata, heads[k]); end
      drive(0, 1, 4'hf, 0);
      n_cmp += 2;
      if (wfull !== 1'b0) begin n_err++; $display("FAIL drain%0d_wfull: got %b want 0", k, wfull); end
      if (rempty !== (k == 3)) begin n_err++; $display("FAIL drain%0d_rempty: got %b want %b", k, rempty, k == 3); end
    end
    drive(0, 1, 4'hf, 0);
    n_cmp += 2;
    if (rempty !== 1'b1) begin n_err++; $display("FAIL extra_rinc_rempty: got %b want 1", rempty); end
    if (wfull !== 1'b0) begin n_err++; $display("FAIL extra_rinc_wfull: got %b want 0", wfull); end
  endtask

  task automatic test_back_to_back();
    pk = '{1, 2, 3, 4, 5};
    write_pkt(0);
    pk = '{7, 8, 9, 6};
    write_pkt(1);
    n_cmp += 3;
    if (rempty !== 1'b0) begin n_err++; $display("FAIL b2b_rempty: got %b want 0", rempty); end
    if (wfull !== 1'b0) begin n_err++; $display("FAIL b2b_wfull: got %b want 0", wfull); end
    if (sb.size() != 1) begin n_err++; $display("FAIL b2b_depth: got %0d want 1", sb.size()); end
    for (int o = 0; o < DEF_WIDTH; o++) begin
      raddr_in = 4'(o); #1;
      n_cmp++;
      if (rdata !== sb[0][o]) begin n_err++; $display("FAIL b2b_byte%0d: got %0d want %0d", o, rdata, sb[0][o]); end
    end
    raddr_in = 4'(OFF_SRC); #1;
    n_cmp++;
    if (rdata !== 8'd7) begin n_err++; $display("FAIL b2b_src: got %0d want 7", rdata); end
  endtask

  task automatic test_full_simul();
    for (int j = 0; j < 3; j++) begin
      pk = '{8'(20 + j), 8'(30 + j), 8'(40 + j)};
      write_pkt(0);
    end
    n_cmp++;
    if (wfull !== 1'b1) begin n_err++; $display("FAIL fs_full: got %b want 1", wfull); end
    drive(1, 1, 4'(OFF_SRC), 8'd77);
    n_cmp += 2;
    if (wfull !== 1'b0) begin n_err++; $display("FAIL fs_wfull: got %b want 0", wfull); end
    if (rempty !== 1'b0) begin n_err++; $display("FAIL fs_rempty: got %b want 0", rempty); end
    drive(1, 0, 4'(OFF_DATA + 2), 8'd42);
    n_cmp++;
    if (wfull !== 1'b1) begin n_err++; $display("FAIL fs_refill: got %b want 1", wfull); end
    for (int k = 0; k < 4; k++) begin
      for (int o = 0; o < DEF_WIDTH; o++) begin
        raddr_in = 4'(o); #1;
        n_cmp++;
        if (rdata !== sb[0][o]) begin n_err++; $display("FAIL fs%0d_byte%0d: got %0d want %0d", k, o, rdata, sb[0][o]); end
      end
      drive(0, 1, 4'hf, 0);
    end
    n_cmp++;
    if (rempty !== 1'b1) begin n_err++; $display("FAIL fs_drained: got %b want 1", rempty); end
  endtask

  task automatic test_reset_mid();
    pk = '{11, 12, 13};
    write_pkt(0);
    pk = '{21, 22, 23, 24};
    write_pkt(0);
    drive(0, 0, 4'(OFF_SRC), 8'd9);
    raddr_in = 4'(OFF_SRC);
    #2 rst = 0;
    #1;
    model_clear();
    n_cmp += 3;
    if (rempty !== 1'b1) begin n_err++; $display("FAIL mid_rst_rempty: got %b want 1", rempty); end
    if (wfull !== 1'b0) begin n_err++; $display("FAIL mid_rst_wfull: got %b want 0", wfull); end
    if (rdata !== 8'd0) begin n_err++; $display("FAIL mid_rst_rdata: got %0d want 0", rdata); end
    @(posedge clk1); #1;
    rst = 1;
    pk = '{5, 6, 7};
    write_pkt(0);
    n_cmp++;
    if (rempty !== 1'b0) begin n_err++; $display("FAIL resume_rempty: got %b want 0", rempty); end
    for (int o = 0; o < DEF_WIDTH; o++) begin
      raddr_in = 4'(o); #1;
      n_cmp++;
      if (rdata !== sb[0][o]) begin n_err++; $display("FAIL resume_byte%0d: got %0d want %0d", o, rdata, sb[0][o]); end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_back_to_back();
    test_full_simul();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 Parameter DEPTH, default 4: number of packet slots.
REQ-002 Parameter WIDTH, default 11: bytes per slot (byte offsets 0..WIDTH-1).
REQ-003 Parameter UWIDTH, default 8: byte width.
REQ-004 Parameter PTR_SZ, default 2: slot index width, equal to log2(DEPTH).
REQ-005 Parameter PTR_IN_SZ, default 4: byte offset width.
REQ-006 Port clk1, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-008 Port winc, input, 1: commit the current write slot.
REQ-009 Port rinc, input, 1: release the head slot.
REQ-010 Port waddr_in, input, PTR_IN_SZ: byte offset for the write.
REQ-011 Port raddr_in, input, PTR_IN_SZ: byte offset for the read.
REQ-012 Port wdata, input, UWIDTH: write byte.
REQ-013 Port rdata, output, UWIDTH: read byte.
REQ-014 Port wfull, output, 1: all DEPTH slots committed.
REQ-015 Port rempty, output, 1: no committed slot.

Function
REQ-016 Storage: DEPTH x WIDTH array of UWIDTH-bit bytes. Each slot holds one packet: source_id, dest_id, size, data..., crc.
REQ-017 Write pointer and read pointer are each PTR_SZ+1 bits wide. Slot index = low PTR_SZ bits. Both pointers wrap modulo 2^(PTR_SZ+1).
REQ-018 Each rising edge with wfull=0 and waddr_in<WIDTH: memory[wptr slot][waddr_in] <= wdata.
REQ-019 When wfull=1 or waddr_in>=WIDTH, the write is dropped.
REQ-020 Rising edge with winc=1 and wfull=0: the same-cycle byte is written (REQ-018), then wptr increments by 1.
REQ-021 winc while wfull=1 is ignored; the pointer and memory stay unchanged.
REQ-022 Bytes written without winc remain staged in the current slot. A later write to the same offset overwrites them.
REQ-023 rdata is combinational: memory[rptr slot][raddr_in] when raddr_in<WIDTH, otherwise 0. It is valid only while rempty=0.
REQ-024 Rising edge with rinc=1 and rempty=0: rptr increments by 1. rinc while rempty=1 is ignored.
REQ-025 rempty = (wptr==rptr).
REQ-026 wfull = (slot bits equal, MSBs differ).
REQ-027 Flags are combinational from registered pointers, so they update in the cycle after the causing edge.
REQ-028 Simultaneous winc and rinc: each is evaluated against the pre-edge flags, and both take effect when permitted.
REQ-029 When full, rinc frees a slot and the simultaneous winc is dropped. When empty, winc commits and rinc is dropped.
REQ-030 Slot data is not cleared on read.

Reset
REQ-031 rst=0 asynchronously clears wptr, rptr and all memory bytes to 0.
REQ-032 During reset, rempty=1, wfull=0 and rdata=0.
REQ-033 Reset asserted mid-packet or mid-read discards all slots. Operation resumes on the first edge after rst returns high.

Structure
REQ-034 Parameter defaults and the packet field offsets (SRC=0, DST=1, SIZE=2, DATA=3) belong in a shared package.
REQ-035 Storage is a sub-module fifo_mem with a synchronous byte write port and a combinational byte read port. Pointer and flag logic stays in fifo.

Verification
REQ-036 Reset, then write bytes 10,160,3,0,1,2,15 at offsets 0..6 with winc on the last byte.
- Next cycle: rempty=0, wfull=0.
- raddr_in=0..6 returns 10,160,3,0,1,2,15.
REQ-037 Commit four packets with no reads:
- Packet 2: 100,10,4,0,1,2,3,55.
- Packet 3: 255,63,5,0..4,55.
- Packet 4: 63,31,6,0..5,127 at offsets 0..9.
- Required: wfull=1 after the fourth winc.
- A fifth winc with wdata=99 changes nothing.
REQ-038 From full, pulse rinc once per cycle.
- raddr_in=0 yields 10, 100, 255, 63 in order.
- wfull drops after the first rinc; rempty=1 after the fourth.
- A further rinc is ignored.
REQ-039 With one slot committed, assert winc and rinc together. Pointers advance together and rempty stays 0.
REQ-040 When full, assert winc and rinc together. The read proceeds, the write is dropped, and wfull=0 next cycle.
REQ-041 Assert rst=0 mid-packet after two commits. Required: rempty=1, wfull=0, rdata=0 immediately, with no clock edge.
